// File: rtl/hazard_scoreboard_unit.sv
// Hazard and forwarding controller: DEPTH-entry in-flight scoreboard driving
// per-operand forwarding selects, load-use stalls, MDU hold and branch flush.
module hazard_scoreboard_unit #(
  parameter int REG_W      = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int MDU_LAT    = 4,
  parameter int CNT_W      = 16,
  parameter int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_wr,
  input  logic             id_is_load,
  input  logic             id_is_mdu,
  input  logic             took_branch,
  output logic [SEL_W-1:0] fwd_sel_a,
  output logic [SEL_W-1:0] fwd_sel_b,
  output logic             stall_id,
  output logic             hold_ex,
  output logic             flush_if,
  output logic             flush_id,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int MCW = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
  localparam logic [MCW-1:0] MDU_INIT = MCW'(MDU_LAT - 1);

  logic [DEPTH:1]   r_v, r_wr, r_ld;
  logic [REG_W-1:0] r_rd [1:DEPTH];
  logic [MCW-1:0]   r_mdu_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic [SEL_W-1:0] w_sel_a, w_sel_b;
  logic             w_ld_a, w_ld_b;
  logic             w_busy, w_branch, w_load_use, w_stall, w_bubble;

  // Scan oldest to youngest so the youngest live producer overwrites older hits.
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    w_ld_a  = 1'b0;
    w_ld_b  = 1'b0;
    for (int unsigned k = DEPTH; k >= 1; k--) begin
      if (r_v[k] && r_wr[k] && (r_rd[k] != '0)) begin
        if (r_rd[k] == id_rs1) begin
          w_sel_a = SEL_W'(k);
          w_ld_a  = r_ld[k];
        end
        if (r_rd[k] == id_rs2) begin
          w_sel_b = SEL_W'(k);
          w_ld_b  = r_ld[k];
        end
      end
    end
  end

  always_comb begin
    w_busy     = (r_mdu_cnt != '0);
    w_branch   = took_branch && !w_busy;
    w_load_use = id_valid &&
                 ((w_ld_a && (w_sel_a < SEL_W'(LOAD_STAGE))) ||
                  (w_ld_b && (w_sel_b < SEL_W'(LOAD_STAGE))));
    w_stall    = w_busy || (w_load_use && !w_branch);
    w_bubble   = w_load_use || w_branch;
  end

  always_comb begin
    fwd_sel_a    = reset ? '0 : w_sel_a;
    fwd_sel_b    = reset ? '0 : w_sel_b;
    stall_id     = !reset && w_stall;
    hold_ex      = !reset && w_busy;
    flush_if     = !reset && w_branch;
    flush_id     = !reset && w_branch;
    mdu_busy     = !reset && w_busy;
    stall_cycles = reset ? '0 : r_stall_cnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v         <= '0;
      r_mdu_cnt   <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_busy) begin
        // MDU op stays in EX; a bubble opens behind it while older stages drain.
        r_mdu_cnt <= r_mdu_cnt - 1'b1;
        r_v[2]    <= 1'b0;
        for (int unsigned k = 3; k <= DEPTH; k++) begin
          r_v[k]  <= r_v[k-1];
          r_rd[k] <= r_rd[k-1];
          r_wr[k] <= r_wr[k-1];
          r_ld[k] <= r_ld[k-1];
        end
      end else begin
        for (int unsigned k = 2; k <= DEPTH; k++) begin
          r_v[k]  <= r_v[k-1];
          r_rd[k] <= r_rd[k-1];
          r_wr[k] <= r_wr[k-1];
          r_ld[k] <= r_ld[k-1];
        end
        r_v[1]  <= id_valid && !w_bubble;
        r_rd[1] <= id_rd;
        r_wr[1] <= id_wr;
        r_ld[1] <= id_is_load;
        if (id_valid && id_is_mdu && !w_bubble)
          r_mdu_cnt <= MDU_INIT;
      end
    end
  end

endmodule

// File: doc/hazard_scoreboard_unit.md
# hazard_scoreboard_unit

Parametrised hazard and forwarding controller for the in-order RISC-V pipeline. It replaces fixed three-stage rd tracking with a DEPTH-entry scoreboard of in-flight instructions. It adds:
- per-operand, priority-encoded forwarding selects;
- a configurable load-ready stage;
- a multi-cycle multiply/divide (MDU) hold counter;
- branch flush;
- a saturating stall-cycle counter.

It sits beside the decode stage and steers the ID/EX operand muxes and the pipeline-register enables.

## Interface
Parameters:
- REG_W, 5, register address width.
- DEPTH, 3, tracked stages ahead of ID (1=EX, 2=MEM, 3=WB, ...); minimum 2.
- LOAD_STAGE, 2, first stage index whose load result is forwardable; range 1..DEPTH.
- MDU_LAT, 4, EX cycles taken by an MDU op; minimum 1.
- CNT_W, 16, stall counter width.
- SEL_W, $clog2(DEPTH+1), derived; not overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  REG_W  source register addresses.
- id_rd  in  REG_W  destination register address.
- id_wr  in  1  ID instruction writes rd.
- id_is_load  in  1  ID instruction is a load.
- id_is_mdu  in  1  ID instruction is an MDU op.
- took_branch  in  1  branch/jump resolved taken in EX this cycle.
- fwd_sel_a, fwd_sel_b  out  SEL_W  0 = register file; k = result of stage k.
- stall_id  out  1  hold PC and IF/ID this cycle.
- hold_ex  out  1  hold ID/EX (MDU busy).
- flush_if, flush_id  out  1  squash younger instructions.
- mdu_busy  out  1  MDU hold counter nonzero.
- stall_cycles  out  CNT_W  saturating count of stall_id cycles.

## Operation
Scoreboard:
- Entry k (1..DEPTH) holds {v, rd, wr, ld}.
- An entry is live when v && wr && rd != 0.

Forwarding, for each operand with rs != 0:
- Select the lowest k whose live entry has rd == rs. The youngest producer wins; older matches are ignored.
- No match gives sel = 0. rs == 0 always gives sel = 0 and never stalls.
- Forwarding is computed even when id_valid = 0; only stalls are gated by id_valid.

Load-use stall:
- Raised when id_valid and the selected producer for rs1 or rs2 has ld = 1 and k < LOAD_STAGE.
- stall_id = 1; forwarding selects are still driven.

MDU hold:
- On an advance where ID has id_valid && id_is_mdu, mdu_cnt loads MDU_LAT-1.
- While mdu_cnt != 0: mdu_busy = hold_ex = stall_id = 1, and mdu_cnt decrements each cycle.

Branch:
- took_branch gives flush_if = flush_id = 1, and stall_id = 0 that cycle. Branch overrides a load-use stall.
- took_branch is ignored while mdu_busy, because a branch cannot be in EX then.

Scoreboard update, one case per edge in priority order:
- **reset:** all v = 0, mdu_cnt = 0, stall_cycles = 0.
- **MDU hold:** entry 1 unchanged; entry 2 gets a bubble (v = 0); entries 3..DEPTH shift from k-1.
- **Load-use stall:** entry 1 gets a bubble; entries 2..DEPTH shift.
- **Flush:** entry 1 gets a bubble (ID instruction discarded); entries 2..DEPTH shift.
- **Advance:** entry 1 gets {id_valid, id_rd, id_wr, id_is_load}; entries 2..DEPTH shift.
- Entry DEPTH retires.

stall_cycles:
- Increments on every edge where stall_id = 1.
- Holds at 2^CNT_W-1.

## Timing
- All outputs are combinational from registered state plus ID inputs, valid in the same cycle. No output is registered except mdu_busy (decoded from mdu_cnt) and stall_cycles.
- During reset all outputs are 0: fwd_sel = 0, every stall/flush/hold = 0, mdu_busy = 0, stall_cycles = 0. They stay 0 in the first cycle after reset.
- Load-use latency:
  - a load at k = 1 with a dependent in ID gives exactly LOAD_STAGE-1 stall cycles;
  - the dependent then advances with fwd_sel = LOAD_STAGE.
- MDU latency: an MDU op holds EX for MDU_LAT-1 extra cycles. A dependent in ID then advances with fwd_sel = 1 on the cycle mdu_cnt == 0.
- A load-use stall and MDU hold at once: MDU hold takes precedence, and only one stall cycle is counted.
- Reset asserted mid-hold or mid-stall: state clears at that edge and the next cycle advances normally.

## Test plan
1. Defaults: ADD x5 enters, then ID reads x5 → fwd_sel_a = 1, stall_id = 0; one bubble later → fwd_sel_a = 2.
2. Same rd at k = 1 and k = 2 with rs2 = that rd → fwd_sel_b = 1. rs1 = x0 with a live x0 write → fwd_sel_a = 0.
3. LW x7 then ADD using x7, with LOAD_STAGE = 2 → 1 stall cycle, then fwd_sel = 2. With LOAD_STAGE = 3 → 2 stall cycles, then fwd_sel = 3; stall_cycles = 2.
4. MDU op with MDU_LAT = 4, dependent in ID → stall_id, hold_ex and mdu_busy high for exactly 3 cycles, then fwd_sel = 1 and mdu_busy = 0.
5. took_branch with a load-use condition in the same cycle → flush_if = flush_id = 1, stall_id = 0, and entry 1 is a bubble next cycle.
6. reset pulse during an MDU hold with mdu_cnt = 2 → next cycle mdu_busy = 0, all fwd_sel = 0, stall_cycles = 0. Separately, with CNT_W = 2 and 5 stall cycles → stall_cycles saturates at 3.
